// File: rtl/spi_slave.sv
// spi_slave: SPI front end for the single-port RAM wrapper.
// Deserialises 10-bit MOSI frames into rx_data/rx_valid and serialises
// 8-bit RAM read data back out on MISO, one bit per clk edge while SS_n is low.
`timescale 1ns/1ps

module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MOSI,
    input  logic       SS_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    output logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Only the low 9 bits of the shift history are needed: the 10th bit
    // is taken straight from MOSI on the completing edge.
    logic [8:0] shift_reg;
    logic [3:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [3:0] tx_cnt;
    logic       rd_addr_done;

    logic       abort;
    logic       rx_active;
    logic       frame_done;
    logic       tx_start;
    logic       tx_run;

    // Next-state decode plus per-cycle datapath strobes.
    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        rx_active  = 1'b0;
        frame_done = 1'b0;
        tx_start   = 1'b0;
        tx_run     = 1'b0;
        if ((state != IDLE) && SS_n) begin
            abort     = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!SS_n) state_nxt = CHK_CMD;
                end
                CHK_CMD: begin
                    if (!MOSI)             state_nxt = WRITE;
                    else if (rd_addr_done) state_nxt = READ_DATA;
                    else                   state_nxt = READ_ADD;
                end
                WRITE, READ_ADD: begin
                    rx_active  = (bit_cnt < 4'd10);
                    frame_done = (bit_cnt == 4'd9);
                end
                READ_DATA: begin
                    rx_active  = (bit_cnt < 4'd10);
                    frame_done = (bit_cnt == 4'd9);
                    // The response is only accepted once, after the frame.
                    tx_start   = (bit_cnt == 4'd10) && (tx_cnt == 4'd0) && tx_valid;
                    tx_run     = (tx_cnt != 4'd0) && (tx_cnt != 4'd8);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Frame reception, rx_data/rx_valid and the read-address flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                bit_cnt <= '0;
            end else if (state == CHK_CMD) begin
                shift_reg <= {shift_reg[7:0], MOSI};
                bit_cnt   <= 4'd1;
            end else if (rx_active) begin
                shift_reg <= {shift_reg[7:0], MOSI};
                bit_cnt   <= bit_cnt + 4'd1;
                if (frame_done) begin
                    rx_data  <= {shift_reg, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)  rd_addr_done <= 1'b1;
                    if (state == READ_DATA) rd_addr_done <= 1'b0;
                end
            end
        end
    end

    // MISO shift-out of the captured RAM byte, MSB first, then held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            MISO     <= 1'b0;
        end else if (abort) begin
            tx_cnt <= '0;
            MISO   <= 1'b0;
        end else if (tx_start) begin
            tx_shift <= {tx_data[6:0], 1'b0};
            tx_cnt   <= 4'd1;
            MISO     <= tx_data[7];
        end else if (tx_run) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt + 4'd1;
            MISO     <= tx_shift[7];
        end else begin
            MISO <= 1'b0;
        end
    end

endmodule
